// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to compile in the parity bit (sense chosen by PARITY_ODD).
module uart_tx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CntW       = $clog2(ClksPerBit) + 1;
  localparam int unsigned BitW       = $clog2(DATA_WIDTH);

  localparam logic [CntW-1:0] CntLast  = CntW'(ClksPerBit - 1);
  localparam logic [BitW-1:0] BitLast  = BitW'(DATA_WIDTH - 1);
  localparam logic            StopLast = (STOP_BITS == 2);

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : gen_bad_width
    $error("uart_tx: DATA_WIDTH must be in 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : gen_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD > 1) begin : gen_bad_parity
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end
  if (ClksPerBit < 1) begin : gen_bad_baud
    $error("uart_tx: BAUD_RATE must not exceed CLK_FREQ");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       baud_q, baud_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic                  stop_q, stop_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
  logic                  bit_end;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  assign bit_end = (baud_q == CntLast);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    // Baud counter only runs inside a frame and wraps on every bit boundary.
    if (state_q != StIdle) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (tx_valid) begin
          state_d = StStart;
          shift_d = tx_data;
          tx_d    = 1'b0;
          bit_d   = '0;
          stop_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = (^tx_data) ^ (PARITY_ODD != 0);
`endif
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BitLast) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
            tx_d    = parity_q;
`else
            state_d = StStop;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          tx_d    = 1'b1;
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          if (stop_q == StopLast) begin
            state_d = StIdle;
            stop_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign tx_done  = done_q;
  assign tx_busy  = (state_q != StIdle);
  assign tx_ready = (state_q == StIdle);

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus pushes expected frames, a line monitor pops and compares.
module tb_uart_tx;

  localparam int unsigned DW       = 8;
  localparam int unsigned CLK_FREQ = 100000000;
  localparam int unsigned BAUD     = 10000000;
  localparam int unsigned SB       = 2;
  localparam int unsigned PO       = 0;
  localparam int unsigned N        = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned PB = 1;
`else
  localparam int unsigned PB = 0;
`endif
  localparam int unsigned FRAME_BITS = 1 + DW + PB + SB;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready, tx, tx_busy, tx_done;

  always #5 clk = ~clk;

  uart_tx #(
    .DATA_WIDTH(DW),
    .BAUD_RATE (BAUD),
    .CLK_FREQ  (CLK_FREQ),
    .STOP_BITS (SB),
    .PARITY_ODD(PO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  typedef struct {
    logic [15:0]   bits;
    logic [DW-1:0] word;
  } frame_t;

  frame_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int frames_done = 0;
  int aborted = 0;
  int last_gap = -1;
  int last_len = -1;
  int prev_done_cyc = -1000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Line-level model: the frame as a list of bit values, index 0 transmitted first.
  function automatic frame_t make_frame(input logic [DW-1:0] w);
    frame_t f;
    int ones = 0;
    f.word = w;
    f.bits = '1;
    f.bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) begin
      f.bits[1 + i] = w[i];
      ones += int'(w[i]);
    end
    if (PB == 1) f.bits[1 + DW] = ((ones % 2) == 1) ^ (PO != 0);
    return f;
  endfunction

  // Monitor: every negedge, follow the line; a frame starts at the first low sample while idle.
  initial begin
    bit     in_frame = 1'b0;
    int     c = 0;
    int     start_cyc = 0;
    frame_t cur;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        if (in_frame) aborted++;
        in_frame = 1'b0;
        continue;
      end
      if (!in_frame) begin
        if (tx === 1'b0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 32'd1, 32'd0);
          end else begin
            cur       = exp_q.pop_front();
            in_frame  = 1'b1;
            c         = 0;
            start_cyc = cyc;
            last_gap  = cyc - prev_done_cyc;
          end
        end else begin
          check("done_idle", tx_done, 1'b0);
          check("busy_idle", tx_busy, 1'b0);
          check("ready_idle", tx_ready, 1'b1);
        end
      end
      if (in_frame) begin
        if (c < int'(FRAME_BITS * N)) begin
          check($sformatf("tx_bit%0d_w%0h", c / N, cur.word), tx, cur.bits[c / N]);
          check("busy_in_frame", tx_busy, 1'b1);
          check("ready_in_frame", tx_ready, 1'b0);
          check("done_in_frame", tx_done, 1'b0);
          c++;
        end else begin
          check("done_pulse", tx_done, 1'b1);
          check("ready_at_done", tx_ready, 1'b1);
          check("busy_at_done", tx_busy, 1'b0);
          check("tx_at_done", tx, 1'b1);
          last_len      = cyc - start_cyc;
          prev_done_cyc = cyc;
          frames_done++;
          in_frame = 1'b0;
        end
      end
    end
  end

  // Handshake happens on the posedge after a negedge where valid && ready.
  task automatic send(input logic [DW-1:0] w, input bit hold);
    int t = 0;
    @(negedge clk);
    tx_data  = w;
    tx_valid = 1'b1;
    while (!tx_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!tx_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      tx_valid = 1'b0;
      return;
    end
    exp_q.push_back(make_frame(w));
    @(posedge clk);
    if (!hold) #1 tx_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int t = 0;
    while (frames_done < n && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check("frames_done", frames_done, n);
  endtask

  initial begin
    int nf;
    logic [DW-1:0] w;
    bit hold;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_tx", tx, 1'b1);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    send(8'hA5, 1'b0);
    wait_frames(1);
    check("a5_frame_len", last_len, FRAME_BITS * N);

    // Data changes while valid is held must not leak into the running frame.
    send(8'h3C, 1'b1);
    send(8'hFF, 1'b0);
    wait_frames(3);
    check("hold_gap", last_gap, 1);

    send(8'h00, 1'b1);
    send(8'hFF, 1'b0);
    wait_frames(5);
    check("b2b_gap", last_gap, 1);

    send(8'h07, 1'b0);
    wait_frames(6);
    check("x07_frame_len", last_len, FRAME_BITS * N);

    // Reset in the middle of data bit 3 (cycles 41..50 after the handshake).
    send(8'h81, 1'b0);
    repeat (44) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_tx", tx, 1'b1);
    check("midrst_ready", tx_ready, 1'b1);
    check("midrst_busy", tx_busy, 1'b0);
    check("midrst_done", tx_done, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (FRAME_BITS * N + 20) @(negedge clk);
    check("aborted_frames", aborted, 1);
    check("no_done_after_abort", frames_done, 6);

    send(8'h55, 1'b0);
    wait_frames(7);

    nf = 7;
    for (int i = 0; i < 20; i++) begin
      w    = DW'($urandom);
      hold = (i == 19) ? 1'b0 : 1'(($urandom_range(0, 1)));
      send(w, hold);
      nf++;
      if (!hold) repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    wait_frames(nf);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter. Serialises parallel words onto a single line as 8N1-style frames: start bit 0, DATA_WIDTH data bits LSB first, optional parity bit, STOP_BITS stop bits of 1. The upstream logic loads words through a valid/ready handshake. The tx output drives the board TX pin or a loopback into the UART receiver.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..9).
BAUD_RATE, 9600, line bit rate in bits/s.
CLK_FREQ, 100000000, clk frequency in Hz.
STOP_BITS, 1, number of stop bits (1 or 2).
PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
tx_data  input  DATA_WIDTH  word to send; sampled only at handshake.
tx_valid  input  1  upstream has a word.
tx_ready  output  1  block can accept a word; high only in IDLE.
tx  output  1  serial line; idles high.
tx_busy  output  1  frame in progress (not IDLE).
tx_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset values (async assert): tx=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, all counters and the shift register at 0.
- CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, integer division, truncated. The default is 10416.
- Baud counter width is $clog2(CLKS_PER_BIT)+1. The counter runs only outside IDLE and clears on every bit boundary. Every bit, including each stop bit, holds tx for exactly CLKS_PER_BIT cycles.
- Handshake: a transfer occurs on a rising edge where tx_valid && tx_ready.
  - On that edge, tx_data is latched into the shift register and the FSM enters START.
  - tx_data and tx_valid are ignored at all other times. No buffering.
- Latency: tx goes low on the first edge after the handshake. The start bit occupies cycles 1..CLKS_PER_BIT after the handshake.
- FSM states:
  - IDLE: tx=1, tx_ready=1. Goes to START on handshake.
  - START: tx=0 for one bit time, then DATA.
  - DATA: tx = shift register LSB. Shift right once per bit. Bit counter 0..DATA_WIDTH-1. After the last bit, go to PARITY if compiled in, else STOP.
  - PARITY: tx = parity bit for one bit time, then STOP.
  - STOP: tx=1 for STOP_BITS bit times, then IDLE.
- tx_done is high for exactly one cycle: the first IDLE cycle after STOP. It coincides with tx_ready rising.
- tx_busy = (state != IDLE). tx_ready = !tx_busy.
- Back-to-back: if tx_valid is held, the next handshake occurs in the first IDLE cycle. This gives an inter-frame line gap of STOP_BITS bit times plus exactly one clk of idle-high.
- Frame length (no parity) = (1+DATA_WIDTH+STOP_BITS)*CLKS_PER_BIT cycles, from the edge after handshake to the tx_done edge.
- Reset mid-frame: tx returns to 1 immediately, the frame is dropped, and no tx_done is generated. The first frame after reset deassertion is clean.
- tx must be driven from a flop (glitch-free). No combinational path from tx_data or tx_valid to tx.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: the PARITY state is present. The parity bit follows the data MSB.
  - Even parity (PARITY_ODD=0): XOR-reduce of the latched word.
  - Odd parity (PARITY_ODD=1): inverse of the XOR-reduce.
  - The word's parity is computed at handshake from the latched data.
  - Frame length grows by one bit time.
- Undefined: no PARITY state, no parity logic. PARITY_ODD is ignored. DATA goes directly to STOP.

Test Plan:
- All tests use CLK_FREQ=100000000, BAUD_RATE=10000000, so CLKS_PER_BIT=10.
- Reset: assert rst asynchronously mid-cycle -> tx=1, tx_ready=1, tx_busy=0, tx_done=0 without waiting for a clk edge.
- Send 0xA5, STOP_BITS=1, no parity -> tx holds 0,1,0,1,0,0,1,0,1,1 for 10 cycles each, starting 1 cycle after the handshake. tx_done pulses once, 100 cycles after the first start-bit cycle. tx_busy is high for exactly those 100 cycles.
- Hold tx_valid=1 and change tx_data from 0x3C to 0xFF during the frame -> the transmitted bits reflect 0x3C only. A second handshake occurs only when tx_ready=1 again, followed by 0xFF.
- Back-to-back 0x00 then 0xFF with tx_valid held, STOP_BITS=2 -> 20 stop cycles of 1 plus exactly 1 idle cycle before the second start bit. Two tx_done pulses.
- Assert rst during data bit 3 of 0x81 -> tx=1 immediately, no tx_done. A following send of 0x55 produces a correct frame.
- With UART_TX_PARITY_EN, send 0x07 -> parity bit = 1 with PARITY_ODD=0, and 0 with PARITY_ODD=1. Frame length is 110 cycles.
